// File: rtl/imgproc_msg_pkg.sv
// imgproc_msg_pkg: register map, status/payload field layout and FSM states
// shared by the message-FIFO reader.
package imgproc_msg_pkg;

    localparam logic [2:0] ADDR_STATUS = 3'd0;
    localparam logic [2:0] ADDR_MSG    = 3'd1;
    localparam logic [2:0] ADDR_ID     = 3'd2;
    localparam logic [2:0] ADDR_COLOUR = 3'd3;

    localparam int STAT_CNT_LSB   = 8;
    localparam int STAT_CNT_MSB   = 15;
    localparam int STAT_FLUSH_BIT = 4;

    localparam logic [31:0] RBB_ID    = 32'h0052_4242;
    localparam logic [31:0] FLUSH_CMD = 32'h1 << STAT_FLUSH_BIT;

    localparam int COORD_W      = 11;
    localparam int PL_LEFT_LSB  = 16;
    localparam int PL_RIGHT_LSB = 0;

    typedef enum logic [2:0] {
        IDLE, ST_RD, ST_CAP, ID_RD, ID_CAP, PL_RD, PL_CAP, FLUSH
    } state_t;

    // Both 11-bit coordinates must be zero-padded to 16 bits.
    function automatic logic payload_ok(input logic [31:0] p);
        return p[31:27] == 5'b0 && p[15:11] == 5'b0;
    endfunction

endpackage

// File: rtl/imgproc_msg_reader.sv
// imgproc_msg_reader: Avalon-MM master that polls the vision message FIFO and
// latches red-bounding-box messages for the motion controller.
module imgproc_msg_reader
    import imgproc_msg_pkg::*;
#(
    parameter int          POLL_INTERVAL = 1024,
    parameter logic [31:0] MSG_ID        = RBB_ID,
    parameter int          ERR_LIMIT     = 4,
    parameter int          CNT_W         = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    output logic                m_chipselect,
    output logic                m_read,
    output logic                m_write,
    output logic [2:0]          m_address,
    output logic [31:0]         m_writedata,
    input  logic [31:0]         m_readdata,
    output logic                box_valid,
    output logic [COORD_W-1:0]  box_left,
    output logic [COORD_W-1:0]  box_right,
    output logic                box_found,
    output logic [CNT_W-1:0]    err_count,
    output logic                flushing
);

    localparam int PW = $clog2(POLL_INTERVAL + 1);
    localparam int EW = $clog2(ERR_LIMIT + 1);
    localparam logic [PW-1:0] POLL_RELOAD = PW'(POLL_INTERVAL - 1);

    state_t          r_state, w_next;
    logic [PW-1:0]   r_poll;
    logic [EW-1:0]   r_consec;
    logic [7:0]      w_words;
    logic [COORD_W-1:0] w_left, w_right;
    logic            w_id_ok, w_pl_ok, w_good, w_err, w_limit;

    assign w_words = m_readdata[STAT_CNT_MSB:STAT_CNT_LSB];
    assign w_left  = m_readdata[PL_LEFT_LSB +: COORD_W];
    assign w_right = m_readdata[PL_RIGHT_LSB +: COORD_W];
    assign w_id_ok = m_readdata == MSG_ID;
    assign w_pl_ok = payload_ok(m_readdata);
    assign w_good  = r_state == PL_CAP && w_pl_ok;
    assign w_err   = (r_state == ID_CAP && !w_id_ok) || (r_state == PL_CAP && !w_pl_ok);
    assign w_limit = w_err && r_consec == EW'(ERR_LIMIT - 1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = r_poll == '0 ? ST_RD : IDLE;
            ST_RD:   w_next = ST_CAP;
            ST_CAP:  w_next = w_words >= 8'd2 ? ID_RD : IDLE;
            ID_RD:   w_next = ID_CAP;
            ID_CAP:  w_next = w_id_ok ? PL_RD : (w_limit ? FLUSH : ST_RD);
            PL_RD:   w_next = PL_CAP;
            PL_CAP:  w_next = w_limit ? FLUSH : ST_RD;
            FLUSH:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Bus outputs decode straight from state so reset drops them asynchronously.
    always_comb begin
        m_read       = r_state == ST_RD || r_state == ID_RD || r_state == PL_RD;
        m_write      = r_state == FLUSH;
        m_chipselect = m_read || m_write;
        m_address    = (r_state == ID_RD || r_state == PL_RD) ? ADDR_MSG : ADDR_STATUS;
        m_writedata  = m_write ? FLUSH_CMD : 32'h0;
        flushing     = m_write;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_poll    <= POLL_RELOAD;
            r_consec  <= '0;
            err_count <= '0;
        end else begin
            if (r_state == IDLE)
                r_poll <= r_poll == '0 ? POLL_RELOAD : r_poll - 1'b1;
            if (r_state == FLUSH || w_good)
                r_consec <= '0;
            else if (w_err)
                r_consec <= r_consec + 1'b1;
            if (w_err && err_count != '1)
                err_count <= err_count + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            box_valid <= 1'b0;
            box_left  <= '0;
            box_right <= '0;
            box_found <= 1'b0;
        end else begin
            box_valid <= w_good;
            if (w_good) begin
                box_left  <= w_left;
                box_right <= w_right;
                box_found <= w_left <= w_right;
            end
        end
    end

endmodule

// File: tb/tb_imgproc_msg_reader.sv
// tb_imgproc_msg_reader: randomized and directed checks of the message reader
// against a FIFO slave model and a queue-level parsing reference.
module tb_imgproc_msg_reader;
    import imgproc_msg_pkg::*;

    localparam int          PI = 8;
    localparam logic [31:0] ID = 32'h0052_4242;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        m_chipselect, m_read, m_write, box_valid, box_found, flushing;
    logic [2:0]  m_address;
    logic [31:0] m_writedata;
    logic [31:0] m_readdata = 32'h0;
    logic [10:0] box_left, box_right;
    logic [15:0] err_count;

    imgproc_msg_reader #(.POLL_INTERVAL(PI), .MSG_ID(ID), .ERR_LIMIT(4), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .m_chipselect(m_chipselect), .m_read(m_read),
        .m_write(m_write), .m_address(m_address), .m_writedata(m_writedata),
        .m_readdata(m_readdata), .box_valid(box_valid), .box_left(box_left),
        .box_right(box_right), .box_found(box_found), .err_count(err_count),
        .flushing(flushing)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [31:0] fifo[$];
    logic [31:0] scn[$];
    logic [22:0] exp_boxes[$];
    int pops, writes, flush_cyc, stat_reads, box_seen, b2b, rw_bad;
    int exp_err, exp_flush, exp_pops, exp_nbox;
    logic prev_rd = 1'b0;

    // Slave: registered read data, pop on each message-port read, flush on write.
    always @(posedge clk) begin
        if (m_chipselect && m_read) begin
            if (m_address == 3'd0) begin
                m_readdata <= {16'h0, 8'(fifo.size()), 8'h0};
                stat_reads++;
            end else if (m_address == 3'd1) begin
                pops++;
                if (fifo.size() != 0) m_readdata <= fifo.pop_front();
                else m_readdata <= 32'h0;
            end else m_readdata <= 32'h0;
        end
        if (m_chipselect && m_write && m_address == 3'd0 && m_writedata[4])
            fifo.delete();
    end

    always @(negedge clk) begin
        logic [22:0] e;
        if (m_read && prev_rd) b2b++;
        prev_rd = m_read;
        if ((m_read && m_write) || (m_chipselect !== (m_read | m_write))) rw_bad++;
        if (m_write) begin
            writes++;
            chk("wr_addr", 32'(m_address), 32'h0);
            chk("wr_data", m_writedata, 32'h10);
        end
        if (flushing) flush_cyc++;
        if (box_valid) begin
            box_seen++;
            if (exp_boxes.size() == 0) chk("box_extra", 32'h1, 32'h0);
            else begin
                e = exp_boxes.pop_front();
                chk("box_left", 32'(box_left), 32'(e[21:11]));
                chk("box_right", 32'(box_right), 32'(e[10:0]));
                chk("box_found", 32'(box_found), 32'(e[22]));
            end
        end
    end

    // Reference: consume whole messages while at least two words remain.
    task automatic model();
        logic [31:0] w[$];
        logic [31:0] id, p;
        int consec;
        bit bad;
        w = scn;
        exp_boxes.delete();
        exp_err = 0; exp_flush = 0; exp_pops = 0; exp_nbox = 0; consec = 0;
        while (w.size() >= 2) begin
            id = w.pop_front();
            exp_pops++;
            bad = 1;
            if (id == ID) begin
                p = w.pop_front();
                exp_pops++;
                if (p[31:27] == 0 && p[15:11] == 0) begin
                    bad = 0;
                    consec = 0;
                    exp_boxes.push_back({p[26:16] <= p[10:0], p[26:16], p[10:0]});
                    exp_nbox++;
                end
            end
            if (bad) begin
                exp_err++;
                consec++;
                if (consec == 4) begin
                    exp_flush++;
                    consec = 0;
                    w.delete();
                end
            end
        end
    endtask

    task automatic start_scn();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("rst_read", 32'(m_read), 32'h0);
        chk("rst_err", 32'(err_count), 32'h0);
        chk("rst_box", {box_valid, box_found, box_left, box_right}, 32'h0);
        fifo = scn;
        pops = 0; writes = 0; flush_cyc = 0; stat_reads = 0; box_seen = 0; b2b = 0; rw_bad = 0;
        prev_rd = 1'b0;
        reset_n = 1'b1;
    endtask

    task automatic run_scn(input string name);
        model();
        start_scn();
        repeat (8 * (scn.size() + 3) + 40) @(negedge clk);
        chk({name, "_err"}, 32'(err_count), 32'(exp_err));
        chk({name, "_pops"}, 32'(pops), 32'(exp_pops));
        chk({name, "_flushes"}, 32'(writes), 32'(exp_flush));
        chk({name, "_flushcyc"}, 32'(flush_cyc), 32'(exp_flush));
        chk({name, "_boxes"}, 32'(box_seen), 32'(exp_nbox));
        chk({name, "_b2b_read"}, 32'(b2b), 32'h0);
        chk({name, "_bus_rule"}, 32'(rw_bad), 32'h0);
    endtask

    initial begin
        int n;
        logic [10:0] l, r;
        logic [31:0] w;

        scn = '{ID, 32'h0012_0210};
        run_scn("s1");
        chk("s1_left", 32'(box_left), 32'h012);
        chk("s1_right", 32'(box_right), 32'h210);
        chk("s1_found", 32'(box_found), 32'h1);

        scn = '{ID, 32'h027F_0000};
        run_scn("s2");
        chk("s2_left", 32'(box_left), 32'd639);
        chk("s2_right", 32'(box_right), 32'd0);
        chk("s2_found", 32'(box_found), 32'h0);

        scn = '{32'hDEAD_BEEF, ID, 32'h0005_0100};
        run_scn("s3");
        chk("s3_err", 32'(err_count), 32'd1);
        chk("s3_left", 32'(box_left), 32'd5);
        chk("s3_right", 32'(box_right), 32'd256);

        scn = '{32'h1, 32'h2, 32'h3, 32'h4, ID, 32'h0001_0002};
        run_scn("s4");
        chk("s4_err", 32'(err_count), 32'd4);
        chk("s4_writes", 32'(writes), 32'd1);
        chk("s4_flushcyc", 32'(flush_cyc), 32'd1);
        chk("s4_nobox", 32'(box_seen), 32'd0);
        chk("s4_idle", 32'(m_chipselect), 32'h0);

        scn = '{ID};
        run_scn("s5");
        chk("s5_pops", 32'(pops), 32'd0);
        chk("s5_repoll", 32'(stat_reads >= 2), 32'h1);

        // Reset in the middle of the payload read.
        scn = '{ID, 32'h0005_0100};
        exp_boxes.delete();
        start_scn();
        n = 0;
        while (!(m_read && m_address == 3'd1 && pops == 1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("s6_reach_plrd", 32'(n < 100), 32'h1);
        reset_n = 1'b0;
        #1;
        chk("s6_async_read", {m_read, m_chipselect, m_write}, 32'h0);
        chk("s6_async_addr", 32'(m_address), 32'h0);
        chk("s6_async_box", {box_valid, box_found, box_left, box_right}, 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        n = 0;
        while (!(m_read || m_write) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("s6_first_poll_cyc", n, PI);
        chk("s6_first_is_status", {m_read, m_write, 1'b0, m_address}, 32'h20);
        repeat (40) @(negedge clk);
        chk("s6_pops", 32'(pops), 32'd1);
        chk("s6_nobox", 32'(box_seen), 32'd0);
        chk("s6_left", 32'(box_left), 32'd0);

        for (int s = 0; s < 12; s++) begin
            scn.delete();
            for (int m = $urandom_range(1, 6); m > 0; m--) begin
                l = 11'($urandom_range(0, 2047));
                r = 11'($urandom_range(0, 2047));
                case ($urandom_range(0, 7))
                    5: begin
                        w = $urandom;
                        scn.push_back(w == ID ? ~w : w);
                    end
                    6: begin
                        scn.push_back(ID ^ (32'h1 << $urandom_range(0, 31)));
                        scn.push_back({5'b0, l, 5'b0, r});
                    end
                    7: begin
                        scn.push_back(ID);
                        scn.push_back({5'b0, l, 5'b0, r} |
                            (32'h1 << ($urandom_range(0, 1) ? 27 + $urandom_range(0, 4)
                                                            : 11 + $urandom_range(0, 4))));
                    end
                    default: begin
                        scn.push_back(ID);
                        scn.push_back({5'b0, l, 5'b0, r});
                    end
                endcase
            end
            if ($urandom_range(0, 3) == 0) scn.push_back(ID);
            run_scn($sformatf("rnd%0d", s));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
